filter_arbiter: RTL and testbench

FILTER_ARBITER -- requirements
Module: filter_arbiter

---
 rtl/filter_arbiter.sv | 117 +++++++++++
 tb/tb_filter_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/filter_arbiter.sv
// Round-robin arbiter that pulls neighbor pairs out of NUM_FILTER filter buffers
// (1-cycle read latency) and presents them one per cycle on a registered output port.
module filter_arbiter #(
  parameter int NUM_FILTER        = 4,
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 20,
  localparam int PAIR_WIDTH       = 2*PARTICLE_ID_WIDTH + 4*DATA_WIDTH,
  localparam int IDX_WIDTH        = $clog2(NUM_FILTER)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_FILTER-1:0]            particle_pair_available,
  input  logic [NUM_FILTER*PAIR_WIDTH-1:0] filter_pair_data,
  output logic [NUM_FILTER-1:0]            sel,
  input  logic                             pipeline_stall,
  output logic [PARTICLE_ID_WIDTH-1:0]     ref_particle_id_out,
  output logic [PARTICLE_ID_WIDTH-1:0]     neighbor_particle_id_out,
  output logic [DATA_WIDTH-1:0]            r2,
  output logic [DATA_WIDTH-1:0]            dx,
  output logic [DATA_WIDTH-1:0]            dy,
  output logic [DATA_WIDTH-1:0]            dz,
  output logic                             out_valid,
  output logic [IDX_WIDTH-1:0]             out_filter_id
);

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0] ref_id;
    logic [PARTICLE_ID_WIDTH-1:0] neighbor_id;
    logic [DATA_WIDTH-1:0]        r2;
    logic [DATA_WIDTH-1:0]        dz;
    logic [DATA_WIDTH-1:0]        dy;
    logic [DATA_WIDTH-1:0]        dx;
  } pair_t;

  logic [IDX_WIDTH-1:0] ptr;
  logic                 rd_pending;
  logic [IDX_WIDTH-1:0] rd_idx;

  logic                 grant_valid;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic [IDX_WIDTH-1:0] cand;
  logic [IDX_WIDTH-1:0] ptr_next;

  pair_t slices [NUM_FILTER];

  for (genvar i = 0; i < NUM_FILTER; i++) begin : g_unpack
    assign slices[i] = pair_t'(filter_pair_data[i*PAIR_WIDTH +: PAIR_WIDTH]);
  end

  // Scan from the highest rotation offset down so the lowest offset from ptr is
  // the last assignment and therefore wins, without needing a loop break.
  always_comb begin
    // NOTE: every comb output gets a default up front so no path can infer a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (!rst && !pipeline_stall) begin
      for (int k = NUM_FILTER - 1; k >= 0; k--) begin
        cand = IDX_WIDTH'((int'(ptr) + k) % NUM_FILTER);
        if (particle_pair_available[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    sel = '0;
    if (grant_valid) sel = NUM_FILTER'(1) << grant_idx;
  end

  always_comb begin
    ptr_next = ptr;
    if (grant_valid) begin
      ptr_next = (grant_idx == IDX_WIDTH'(NUM_FILTER - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Grant bookkeeping: the buffer answers one cycle after sel, so remember who was asked.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      ptr        <= '0;
      rd_pending <= 1'b0;
      rd_idx     <= '0;
    end else begin
      ptr        <= ptr_next;
      rd_pending <= grant_valid;
      rd_idx     <= grant_valid ? grant_idx : '0;
    end
  end

  // Output stage: fields are zero in any cycle that carries no pair.
  always_ff @(posedge clk) begin
    if (rst || !rd_pending) begin
      out_valid                <= 1'b0;
      out_filter_id            <= '0;
      ref_particle_id_out      <= '0;
      neighbor_particle_id_out <= '0;
      r2                       <= '0;
      dz                       <= '0;
      dy                       <= '0;
      dx                       <= '0;
    end else begin
      out_valid                <= 1'b1;
      out_filter_id            <= rd_idx;
      ref_particle_id_out      <= slices[rd_idx].ref_id;
      neighbor_particle_id_out <= slices[rd_idx].neighbor_id;
      r2                       <= slices[rd_idx].r2;
      dz                       <= slices[rd_idx].dz;
      dy                       <= slices[rd_idx].dy;
      dx                       <= slices[rd_idx].dx;
    end
  end

endmodule

// File: tb/tb_filter_arbiter.sv
// Randomized + directed bench for filter_arbiter against a cycle-level behavioural model.
module tb_filter_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 20;
  localparam int PW = 2*IW + 4*DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      particle_pair_available;
  logic [N*PW-1:0]   filter_pair_data;
  logic [N-1:0]      sel;
  logic              pipeline_stall;
  logic [IW-1:0]     ref_particle_id_out, neighbor_particle_id_out;
  logic [DW-1:0]     r2, dx, dy, dz;
  logic              out_valid;
  logic [1:0]        out_filter_id;

  filter_arbiter #(.NUM_FILTER(N), .DATA_WIDTH(DW), .PARTICLE_ID_WIDTH(IW)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .particle_pair_available  (particle_pair_available),
    .filter_pair_data         (filter_pair_data),
    .sel                      (sel),
    .pipeline_stall           (pipeline_stall),
    .ref_particle_id_out      (ref_particle_id_out),
    .neighbor_particle_id_out (neighbor_particle_id_out),
    .r2                       (r2),
    .dx                       (dx),
    .dy                       (dy),
    .dz                       (dz),
    .out_valid                (out_valid),
    .out_filter_id            (out_filter_id)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model state: round-robin pointer, one outstanding read, expected output registers.
  int          m_ptr;
  bit          m_pend_v;
  int          m_pend_idx;
  bit          m_out_v;
  int          m_out_fid;
  logic [PW-1:0] m_out_pair;

  bit            fixed_mode = 1'b0;
  logic [PW-1:0] fixed_pair;
  logic [N-1:0]  last_sel;
  logic [1:0]    last_fid;
  int            n_valid;

  task automatic cycle(input logic [N-1:0] av, input logic st, input logic r, input bit chk_out);
    int g;
    logic [N-1:0]  exp_sel;
    logic [PW-1:0] obs_pair;
    particle_pair_available = av;
    pipeline_stall          = st;
    rst                     = r;
    for (int w = 0; w < (N*PW)/32; w++) filter_pair_data[w*32 +: 32] = $urandom;
    if (fixed_mode) filter_pair_data[2*PW +: PW] = fixed_pair;
    #1;
    // Round-robin rule: visit filters in the order ptr, ptr+1, ... wrapping; take the first ready one.
    g = -1;
    if (!r && !st) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && av[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_sel = '0;
    if (g >= 0) exp_sel[g] = 1'b1;
    check("sel", 256'(sel), 256'(exp_sel));
    if (chk_out) begin
      obs_pair = {ref_particle_id_out, neighbor_particle_id_out, r2, dz, dy, dx};
      check("out_valid", 256'(out_valid), 256'(m_out_v));
      check("out_filter_id", 256'(out_filter_id), 256'(m_out_fid));
      check("out_fields", 256'(obs_pair), 256'(m_out_pair));
    end
    last_sel = sel;
    last_fid = out_filter_id;
    if (out_valid === 1'b1) n_valid++;
    if (r) begin
      m_ptr = 0; m_pend_v = 0; m_pend_idx = 0;
      m_out_v = 0; m_out_fid = 0; m_out_pair = '0;
    end else begin
      m_out_v    = m_pend_v;
      m_out_fid  = m_pend_v ? m_pend_idx : 0;
      m_out_pair = m_pend_v ? filter_pair_data[m_pend_idx*PW +: PW] : '0;
      m_pend_v   = (g >= 0);
      m_pend_idx = (g >= 0) ? g : 0;
      if (g >= 0) m_ptr = (g + 1) % N;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle('0, 1'b0, 1'b1, 1'b1);
    cycle('0, 1'b0, 1'b1, 1'b1);
  endtask

  logic [N-1:0] seq_sel [5];
  logic [1:0]   seq_fid [5];
  logic [N-1:0] exp_seq [5];

  initial begin
    m_ptr = 0; m_pend_v = 0; m_pend_idx = 0; m_out_v = 0; m_out_fid = 0; m_out_pair = '0;
    fixed_pair = {20'd5, 20'd9, 32'h42C8_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;

    // Outputs are unknown before the first reset edge, so skip output checks once.
    cycle('0, 1'b0, 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b1, 1'b1);

    // Idle: nothing available for 10 cycles.
    n_valid = 0;
    for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    check("idle_valid_count", 256'(n_valid), 256'(0));

    // All filters ready: strict rotation, continuous output two cycles after first grant.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(4'b1111, 1'b0, 1'b0, 1'b1);
      if (i < 5) seq_sel[i] = last_sel;
      if (i >= 2) seq_fid[i-2] = last_fid;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_sel%0d", i), 256'(seq_sel[i]), 256'(exp_seq[i]));
      check($sformatf("rr_fid%0d", i), 256'(seq_fid[i]), 256'(i % N));
    end

    // Only filter 2 ready, fixed pair contents.
    do_reset();
    fixed_mode = 1'b1;
    for (int i = 0; i < 6; i++) cycle(4'b0100, 1'b0, 1'b0, 1'b1);
    check("f2_sel", 256'(last_sel), 256'(4'b0100));
    check("f2_ref", 256'(ref_particle_id_out), 256'(20'd5));
    check("f2_nbr", 256'(neighbor_particle_id_out), 256'(20'd9));
    check("f2_r2", 256'(r2), 256'(32'h42C8_0000));
    check("f2_dz", 256'(dz), 256'(32'h3F80_0000));
    check("f2_dy", 256'(dy), 256'(32'h4000_0000));
    check("f2_dx", 256'(dx), 256'(32'h4040_0000));
    check("f2_fid", 256'(out_filter_id), 256'(2));
    fixed_mode = 1'b0;

    // Pointer at 2 with filter 2 absent: 3, wrap to 0, then 1.
    do_reset();
    cycle(4'b0010, 1'b0, 1'b0, 1'b1);
    cycle(4'b1011, 1'b0, 1'b0, 1'b1);
    check("skip_a", 256'(last_sel), 256'(4'b1000));
    cycle(4'b1011, 1'b0, 1'b0, 1'b1);
    check("skip_b", 256'(last_sel), 256'(4'b0001));
    cycle(4'b1011, 1'b0, 1'b0, 1'b1);
    check("skip_c", 256'(last_sel), 256'(4'b0010));

    // Stall after two grants: in-flight reads still land, then resume at ptr=2.
    do_reset();
    cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    n_valid = 0;
    for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b1, 1'b0, 1'b1);
    check("stall_drain_count", 256'(n_valid), 256'(2));
    cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    check("stall_resume_sel", 256'(last_sel), 256'(4'b0100));

    // Reset right after a grant drops the in-flight read.
    cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    cycle(4'b1111, 1'b0, 1'b1, 1'b1);
    n_valid = 0;
    cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    check("rst_drop_count", 256'(n_valid), 256'(0));
    cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    check("rst_ptr_zero", 256'(last_sel), 256'(4'b0001));

    // Random traffic with occasional stalls and resets.
    for (int i = 0; i < 400; i++) begin
      cycle(N'($urandom), ($urandom_range(4) == 0), ($urandom_range(49) == 0), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
